bcd_score_counter_display: RTL
==============================

// Module: bcd_score_counter_display
// PURPOSE
//  Multi-digit decimal score counter with a registered 7-segment driver per digit.
//  Counts in BCD with saturation, blanks leading zeros and can blink the whole display.
//  Sits between the game FSM (inc/dec/clear pulses) and the board HEX displays.
//  Replaces per-digit combinational decoders fed by external binary counters.
// PARAMETERS
//  DIGITS     2   number of decimal digits (1..6); max score = 10^DIGITS-1
//  BLINK_DIV  25000000  CLOCK cycles per blink half-period (>=1)
//  BLANK_LZ   1   1: blank leading-zero digits; 0: show all digits
// PORTS
//  CLOCK     in   1          system clock, rising edge
//  RESET     in   1          asynchronous, active-low reset
//  clear     in   1          synchronous clear of score to 0
//  inc       in   1          +1 request, sampled each rising edge
//  dec       in   1          -1 request, sampled each rising edge
//  blink_en  in   1          1: display flashes on/off at BLINK_DIV rate
//  score     out  4*DIGITS   BCD score; digit i at [4i+3:4i], digit 0 = units
//  at_max    out  1          1 when score == all nines
//  HEX       out  7*DIGITS   active-low segments; digit i at [7i+6:7i], bit 7i+6=a .. 7i+0=g
// BEHAVIOUR
//  Reset (RESET=0, async): score=0, at_max=0, blink phase=ON, blink counter=0;
//   HEX digit0 = 7'b0000001 ("0"); other digits 7'b1111111 if BLANK_LZ else 7'b0000001.
//  Score update, priority per edge: clear > (inc&dec: no change) > inc > dec.
//  inc: BCD +1 with ripple carry within the same cycle (e.g. 0199 -> 0200).
//  dec: BCD -1 with ripple borrow (e.g. 0200 -> 0199).
//  Saturation: inc at max holds max; dec at 0 holds 0; no wrap, no flag beyond at_max.
//  score and at_max registered: request sampled at edge N visible after edge N.
//  Digit nibbles never hold 10..15; decoder maps such codes to blank (defensive).
//  Segment code (abcdefg, active-high before inversion): 0=1111110 1=0110000
//   2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011;
//   HEX drives the bitwise inverse.
//  Leading-zero blank (BLANK_LZ=1): digit i>0 blank when it and all higher digits are 0;
//   digit 0 never blanked by this rule.
//  HEX registered from score: one cycle after score changes (total latency 2 edges).
//  Blink: blink_en=1 -> counter counts 0..BLINK_DIV-1, phase toggles on terminal count;
//   phase OFF forces every HEX digit to 7'b1111111. blink_en=0 -> counter=0, phase=ON
//   on the next edge. Blinking does not affect score or at_max.
//  blink_en rising: first OFF phase starts BLINK_DIV cycles after it is sampled high.
//  RESET asserted mid-count or mid-blink: all state returns to reset values immediately.
// TESTING
//  1 DIGITS=2: reset -> score=8'h00, HEX={7'h7F,7'h01}, at_max=0.
//  2 score 09, inc 1 cycle -> score=8'h10 next edge; HEX={7'h4F,7'h01} one edge later.
//  3 99 inc pulses from 00 -> score=8'h99, at_max=1; 1 more inc -> still 99; dec -> 98, at_max=0.
//  4 score 00, dec -> stays 00; score 42, inc&dec same cycle -> 42; clear&inc -> 00.
//  5 BLINK_DIV=4, score 07, blink_en=1 -> HEX alternates {7F,0F} / {7F,7F} every 4 cycles;
//    blink_en=0 -> {7F,0F} steady from next edge.
//  6 RESET low while blinking at score 55 -> score=00, HEX reset value, blink phase ON at release.

Source files
------------

// File: rtl/bcd_score_counter_display.sv
// Saturating BCD score counter with a registered, blinkable 7-segment driver per digit.
// Latency: score/at_max one edge after a request, HEX one edge after score; no backpressure.
module bcd_score_counter_display #(
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25000000,
  parameter int BLANK_LZ  = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  clear,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  blink_en,
  output logic [4*DIGITS-1:0]   score,
  output logic                  at_max,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int SW = 4 * DIGITS;
  localparam int HW = 7 * DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TERM  = CW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

  function automatic logic [HW-1:0] hex_rst_val();
    logic [HW-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++)
      v[7*i +: 7] = (i > 0 && BLANK_LZ != 0) ? 7'h7F : 7'h01;
    return v;
  endfunction

  localparam logic [HW-1:0] HEX_RST = hex_rst_val();

  // Active-high abcdefg; non-decimal codes decode to all-off.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [SW-1:0] score_q, score_d;
  logic          at_max_q, at_max_d;
  logic [HW-1:0] hex_q, hex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  logic [SW-1:0] inc_v, dec_v;
  logic          carry, borrow;
  logic [3:0]    dig;

  always_comb begin
    inc_v  = score_q;
    dec_v  = score_q;
    carry  = 1'b1;
    borrow = 1'b1;
    dig    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = score_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d = score_q;
    if (clear)
      score_d = '0;
    else if (inc && dec)
      score_d = score_q;
    else if (inc && score_q != NINES)
      score_d = inc_v;
    else if (dec && score_q != '0)
      score_d = dec_v;
    at_max_d = (score_d == NINES);
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  logic       lz;
  logic [6:0] seg;
  logic [3:0] hd;

  // Walk from the most significant digit so lz tracks "everything above is zero".
  always_comb begin
    hex_d = '0;
    lz    = 1'b1;
    seg   = '0;
    hd    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hd  = score_q[4*i +: 4];
      seg = ~seg7(hd);
      if (BLANK_LZ != 0 && i > 0 && lz && hd == 4'd0)
        seg = 7'h7F;
      if (hd != 4'd0)
        lz = 1'b0;
      if (blink_en && !phase_q)
        seg = 7'h7F;
      hex_d[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      score_q  <= '0;
      at_max_q <= 1'b0;
      hex_q    <= HEX_RST;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      score_q  <= score_d;
      at_max_q <= at_max_d;
      hex_q    <= hex_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign score  = score_q;
  assign at_max = at_max_q;
  assign HEX    = hex_q;

endmodule
